// File: rtl/psum_accumulator.sv
// Sums NUM_GROUPS beats of CH signed partial sums per channel into saturating ACC_W accumulators.
// The result is valid the cycle after the last beat is captured; while it is held, data_in_ready stays low until data_out_ready.
module psum_accumulator #(
  parameter int CH         = 64,
  parameter int IN_W       = 8,
  parameter int ACC_W      = 12,
  parameter int NUM_GROUPS = 9,
  localparam int CNT_W     = $clog2(NUM_GROUPS + 1)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      data_in_valid,
  output logic                      data_in_ready,
  input  logic [CH-1:0][IN_W-1:0]   data_in,
  output logic                      data_out_valid,
  input  logic                      data_out_ready,
  output logic [CH-1:0][ACC_W-1:0]  data_out,
  output logic [CNT_W-1:0]          group_cnt
);

  localparam logic [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

  typedef enum logic {ACCUM, HOLD} state_t;

  state_t                    state;
  logic [CH-1:0][ACC_W-1:0]  acc;
  logic [CH-1:0][ACC_W-1:0]  acc_nxt;
  logic                      in_fire;
  logic                      last_beat;

  function automatic logic [ACC_W-1:0] sext(input logic [IN_W-1:0] b);
    return {{(ACC_W-IN_W){b[IN_W-1]}}, b};
  endfunction

  // One guard bit: overflow shows up as the top two sum bits disagreeing.
  function automatic logic [ACC_W-1:0] sat_add(input logic [ACC_W-1:0] a,
                                               input logic [IN_W-1:0]  b);
    logic [ACC_W:0] s;
    s = {a[ACC_W-1], a} + {{(ACC_W+1-IN_W){b[IN_W-1]}}, b};
    if (s[ACC_W] != s[ACC_W-1])
      return s[ACC_W] ? ACC_MIN : ACC_MAX;
    return s[ACC_W-1:0];
  endfunction

  assign in_fire   = data_in_valid & data_in_ready;
  assign last_beat = (group_cnt == CNT_W'(NUM_GROUPS - 1));
  assign data_out  = acc;

  // The first beat of a group overwrites, so the previous result needs no clear.
  always_comb begin
    acc_nxt = acc;
    for (int k = 0; k < CH; k++)
      acc_nxt[k] = (group_cnt == '0) ? sext(data_in[k]) : sat_add(acc[k], data_in[k]);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= ACCUM;
      group_cnt      <= '0;
      acc            <= '0;
      data_out_valid <= 1'b0;
      data_in_ready  <= 1'b0;
    end else begin
      case (state)
        ACCUM: begin
          data_in_ready <= 1'b1;
          if (in_fire) begin
            acc <= acc_nxt;
            if (last_beat) begin
              group_cnt      <= CNT_W'(NUM_GROUPS);
              state          <= HOLD;
              data_out_valid <= 1'b1;
              data_in_ready  <= 1'b0;
            end else begin
              group_cnt <= group_cnt + CNT_W'(1);
            end
          end
        end
        HOLD: begin
          if (data_out_ready) begin
            data_out_valid <= 1'b0;
            data_in_ready  <= 1'b1;
            group_cnt      <= '0;
            state          <= ACCUM;
          end
        end
        default: state <= ACCUM;
      endcase
    end
  end

endmodule

// File: tb/tb_psum_accumulator.sv
// Directed bench for psum_accumulator: default, 32-group and single-group instances share clk/rst.
module tb_psum_accumulator;
  localparam int CH = 64;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // NUM_GROUPS = 9
  logic                 a_vld = 1'b0, a_rdy, a_ovld, a_ordy = 1'b0;
  logic [CH-1:0][7:0]   a_din = '0;
  logic [CH-1:0][11:0]  a_dout;
  logic [3:0]           a_cnt;
  // NUM_GROUPS = 32
  logic                 b_vld = 1'b0, b_rdy, b_ovld, b_ordy = 1'b0;
  logic [CH-1:0][7:0]   b_din = '0;
  logic [CH-1:0][11:0]  b_dout;
  logic [5:0]           b_cnt;
  // NUM_GROUPS = 1
  logic                 c_vld = 1'b0, c_rdy, c_ovld, c_ordy = 1'b0;
  logic [CH-1:0][7:0]   c_din = '0;
  logic [CH-1:0][11:0]  c_dout;
  logic [0:0]           c_cnt;

  psum_accumulator #(.NUM_GROUPS(9)) u_a (
    .clk(clk), .rst(rst), .data_in_valid(a_vld), .data_in_ready(a_rdy), .data_in(a_din),
    .data_out_valid(a_ovld), .data_out_ready(a_ordy), .data_out(a_dout), .group_cnt(a_cnt));
  psum_accumulator #(.NUM_GROUPS(32)) u_b (
    .clk(clk), .rst(rst), .data_in_valid(b_vld), .data_in_ready(b_rdy), .data_in(b_din),
    .data_out_valid(b_ovld), .data_out_ready(b_ordy), .data_out(b_dout), .group_cnt(b_cnt));
  psum_accumulator #(.NUM_GROUPS(1)) u_c (
    .clk(clk), .rst(rst), .data_in_valid(c_vld), .data_in_ready(c_rdy), .data_in(c_din),
    .data_out_valid(c_ovld), .data_out_ready(c_ordy), .data_out(c_dout), .group_cnt(c_cnt));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic a_fill(input int v);
    for (int k = 0; k < CH; k++) a_din[k] = 8'(v);
  endtask

  task automatic a_beat(input int v);
    a_vld = 1'b1;
    a_fill(v);
    tick();
    a_vld = 1'b0;
  endtask

  task automatic test_reset();
    #2;
    tests++; if (a_ovld !== 1'b0) begin fails++; $display("FAIL reset_ovld: got %0d expected 0", a_ovld); end
    tests++; if (a_rdy !== 1'b0) begin fails++; $display("FAIL reset_rdy: got %0d expected 0", a_rdy); end
    tests++; if (a_cnt !== 4'd0) begin fails++; $display("FAIL reset_cnt: got %0d expected 0", a_cnt); end
    tests++; if (a_dout !== '0) begin fails++; $display("FAIL reset_dout: got %h expected 0", a_dout[0]); end
    tick();
    rst = 1'b0;
    tick();
    tests++; if (a_rdy !== 1'b1) begin fails++; $display("FAIL reset_rdy_after: got %0d expected 1", a_rdy); end
    tests++; if (b_rdy !== 1'b1) begin fails++; $display("FAIL reset_b_rdy_after: got %0d expected 1", b_rdy); end
  endtask

  task automatic test_basic();
    a_ordy = 1'b1;
    for (int i = 0; i < 9; i++) begin
      tests++; if (a_cnt !== 4'(i)) begin fails++; $display("FAIL basic_cnt: got %0d expected %0d", a_cnt, i); end
      tests++; if (a_ovld !== 1'b0) begin fails++; $display("FAIL basic_early_vld: got %0d expected 0 at beat %0d", a_ovld, i); end
      a_beat(3);
    end
    tests++; if (a_ovld !== 1'b1) begin fails++; $display("FAIL basic_vld: got %0d expected 1", a_ovld); end
    tests++; if (a_rdy !== 1'b0) begin fails++; $display("FAIL basic_rdy_hold: got %0d expected 0", a_rdy); end
    tests++; if (a_cnt !== 4'd9) begin fails++; $display("FAIL basic_cnt_full: got %0d expected 9", a_cnt); end
    for (int k = 0; k < CH; k++) begin
      tests++; if (a_dout[k] !== 12'd27) begin fails++; $display("FAIL basic_ch%0d: got %0d expected 27", k, $signed(a_dout[k])); end
    end
    tick();
    tests++; if (a_ovld !== 1'b0) begin fails++; $display("FAIL basic_vld_drop: got %0d expected 0", a_ovld); end
    tests++; if (a_cnt !== 4'd0) begin fails++; $display("FAIL basic_cnt_clear: got %0d expected 0", a_cnt); end
    tests++; if (a_rdy !== 1'b1) begin fails++; $display("FAIL basic_rdy_back: got %0d expected 1", a_rdy); end
  endtask

  task automatic test_mixed();
    logic [11:0] e;
    for (int i = 0; i < 9; i++) begin
      if (i == 4) begin
        tick();
        tests++; if (a_cnt !== 4'd4) begin fails++; $display("FAIL mixed_bubble_cnt: got %0d expected 4", a_cnt); end
      end
      a_vld = 1'b1;
      for (int k = 0; k < CH; k++) a_din[k] = 8'(k - 32);
      tick();
      a_vld = 1'b0;
    end
    tests++; if (a_ovld !== 1'b1) begin fails++; $display("FAIL mixed_vld: got %0d expected 1", a_ovld); end
    for (int k = 0; k < CH; k++) begin
      e = 12'(9 * (k - 32));
      tests++; if (a_dout[k] !== e) begin fails++; $display("FAIL mixed_ch%0d: got %0d expected %0d", k, $signed(a_dout[k]), $signed(e)); end
    end
    tick();
  endtask

  task automatic test_x_ignored();
    for (int i = 0; i < 3; i++) a_beat(1);
    a_din = 'x;
    tick();
    tick();
    tests++; if (a_cnt !== 4'd3) begin fails++; $display("FAIL x_cnt: got %0d expected 3", a_cnt); end
    for (int i = 0; i < 6; i++) a_beat(1);
    tests++; if (a_ovld !== 1'b1) begin fails++; $display("FAIL x_vld: got %0d expected 1", a_ovld); end
    tests++; if (a_dout[0] !== 12'd9) begin fails++; $display("FAIL x_ch0: got %h expected 9", a_dout[0]); end
    tests++; if (a_dout[63] !== 12'd9) begin fails++; $display("FAIL x_ch63: got %h expected 9", a_dout[63]); end
    tick();
  endtask

  task automatic test_backpressure();
    a_ordy = 1'b0;
    for (int i = 0; i < 9; i++) a_beat(2);
    for (int c = 0; c < 5; c++) begin
      a_vld = 1'b1;
      a_fill(50);
      tick();
      tests++; if (a_rdy !== 1'b0) begin fails++; $display("FAIL bp_rdy: got %0d expected 0", a_rdy); end
      tests++; if (a_ovld !== 1'b1) begin fails++; $display("FAIL bp_vld: got %0d expected 1", a_ovld); end
      tests++; if (a_cnt !== 4'd9) begin fails++; $display("FAIL bp_cnt: got %0d expected 9", a_cnt); end
      tests++; if (a_dout[0] !== 12'd18) begin fails++; $display("FAIL bp_ch0: got %0d expected 18", $signed(a_dout[0])); end
      tests++; if (a_dout[63] !== 12'd18) begin fails++; $display("FAIL bp_ch63: got %0d expected 18", $signed(a_dout[63])); end
    end
    a_ordy = 1'b1;
    tick();
    tests++; if (a_ovld !== 1'b0) begin fails++; $display("FAIL bp_release_vld: got %0d expected 0", a_ovld); end
    tests++; if (a_rdy !== 1'b1) begin fails++; $display("FAIL bp_release_rdy: got %0d expected 1", a_rdy); end
    tests++; if (a_cnt !== 4'd0) begin fails++; $display("FAIL bp_release_cnt: got %0d expected 0", a_cnt); end
    tests++; if (a_dout[0] !== 12'd18) begin fails++; $display("FAIL bp_release_ch0: got %0d expected 18", $signed(a_dout[0])); end
    tick();
    a_vld = 1'b0;
    tests++; if (a_dout[0] !== 12'd50) begin fails++; $display("FAIL bp_first_ch0: got %0d expected 50", $signed(a_dout[0])); end
    tests++; if (a_dout[63] !== 12'd50) begin fails++; $display("FAIL bp_first_ch63: got %0d expected 50", $signed(a_dout[63])); end
    tests++; if (a_cnt !== 4'd1) begin fails++; $display("FAIL bp_first_cnt: got %0d expected 1", a_cnt); end
    for (int i = 0; i < 8; i++) a_beat(0);
    tests++; if (a_ovld !== 1'b1) begin fails++; $display("FAIL bp_group2_vld: got %0d expected 1", a_ovld); end
    tests++; if (a_dout[5] !== 12'd50) begin fails++; $display("FAIL bp_group2_ch5: got %0d expected 50", $signed(a_dout[5])); end
    tick();
  endtask

  task automatic test_reset_mid();
    a_ordy = 1'b1;
    for (int i = 0; i < 5; i++) a_beat(1);
    tests++; if (a_cnt !== 4'd5) begin fails++; $display("FAIL rmid_cnt_pre: got %0d expected 5", a_cnt); end
    tests++; if (a_dout[0] !== 12'd5) begin fails++; $display("FAIL rmid_ch0_pre: got %0d expected 5", $signed(a_dout[0])); end
    #3;
    rst = 1'b1;
    #1;
    tests++; if (a_ovld !== 1'b0) begin fails++; $display("FAIL rmid_vld: got %0d expected 0", a_ovld); end
    tests++; if (a_rdy !== 1'b0) begin fails++; $display("FAIL rmid_rdy: got %0d expected 0", a_rdy); end
    tests++; if (a_cnt !== 4'd0) begin fails++; $display("FAIL rmid_cnt: got %0d expected 0", a_cnt); end
    tests++; if (a_dout !== '0) begin fails++; $display("FAIL rmid_dout: got %h expected 0", a_dout[0]); end
    a_vld = 1'b1;
    a_fill(9);
    tick();
    tests++; if (a_cnt !== 4'd0) begin fails++; $display("FAIL rmid_held_cnt: got %0d expected 0", a_cnt); end
    tests++; if (a_dout[0] !== 12'd0) begin fails++; $display("FAIL rmid_held_ch0: got %0d expected 0", $signed(a_dout[0])); end
    a_vld = 1'b0;
    rst = 1'b0;
    tick();
    tests++; if (a_rdy !== 1'b1) begin fails++; $display("FAIL rmid_rdy_after: got %0d expected 1", a_rdy); end
    for (int i = 0; i < 9; i++) a_beat(1);
    tests++; if (a_ovld !== 1'b1) begin fails++; $display("FAIL rmid_fresh_vld: got %0d expected 1", a_ovld); end
    tests++; if (a_dout[0] !== 12'd9) begin fails++; $display("FAIL rmid_fresh_ch0: got %0d expected 9", $signed(a_dout[0])); end
    tests++; if (a_dout[63] !== 12'd9) begin fails++; $display("FAIL rmid_fresh_ch63: got %0d expected 9", $signed(a_dout[63])); end
    tick();
  endtask

  task automatic test_saturation();
    b_ordy = 1'b1;
    tests++; if (b_rdy !== 1'b1) begin fails++; $display("FAIL sat_rdy: got %0d expected 1", b_rdy); end
    for (int i = 0; i < 32; i++) begin
      b_vld = 1'b1;
      b_din[0] = 8'd127;
      b_din[1] = 8'h80;
      b_din[2] = 8'd1;
      b_din[3] = (i < 20) ? 8'd127 : 8'h80;
      b_din[4] = (i < 20) ? 8'h80 : 8'd127;
      tick();
      b_vld = 1'b0;
      if (i == 15) begin
        tests++; if (b_dout[0] !== 12'd2032) begin fails++; $display("FAIL sat_ch0_16: got %0d expected 2032", $signed(b_dout[0])); end
        tests++; if (b_dout[1] !== 12'h800) begin fails++; $display("FAIL sat_ch1_16: got %0d expected -2048", $signed(b_dout[1])); end
      end
      if (i == 16) begin
        tests++; if (b_dout[0] !== 12'd2047) begin fails++; $display("FAIL sat_ch0_17: got %0d expected 2047", $signed(b_dout[0])); end
        tests++; if (b_dout[1] !== 12'h800) begin fails++; $display("FAIL sat_ch1_17: got %0d expected -2048", $signed(b_dout[1])); end
      end
    end
    tests++; if (b_ovld !== 1'b1) begin fails++; $display("FAIL sat_vld: got %0d expected 1", b_ovld); end
    tests++; if (b_cnt !== 6'd32) begin fails++; $display("FAIL sat_cnt: got %0d expected 32", b_cnt); end
    tests++; if (b_dout[0] !== 12'd2047) begin fails++; $display("FAIL sat_ch0: got %0d expected 2047", $signed(b_dout[0])); end
    tests++; if (b_dout[1] !== 12'h800) begin fails++; $display("FAIL sat_ch1: got %0d expected -2048", $signed(b_dout[1])); end
    tests++; if (b_dout[2] !== 12'd32) begin fails++; $display("FAIL sat_ch2: got %0d expected 32", $signed(b_dout[2])); end
    tests++; if (b_dout[3] !== 12'd511) begin fails++; $display("FAIL sat_ch3_recover: got %0d expected 511", $signed(b_dout[3])); end
    tests++; if (b_dout[4] !== 12'(-524)) begin fails++; $display("FAIL sat_ch4_recover: got %0d expected -524", $signed(b_dout[4])); end
    tests++; if (b_dout[5] !== 12'd0) begin fails++; $display("FAIL sat_ch5: got %0d expected 0", $signed(b_dout[5])); end
    tick();
    tests++; if (b_ovld !== 1'b0) begin fails++; $display("FAIL sat_vld_drop: got %0d expected 0", b_ovld); end
  endtask

  task automatic test_num_groups_one();
    c_ordy = 1'b1;
    tests++; if (c_rdy !== 1'b1) begin fails++; $display("FAIL ng1_rdy0: got %0d expected 1", c_rdy); end
    c_vld = 1'b1;
    for (int k = 0; k < CH; k++) c_din[k] = 8'd5;
    tick();
    tests++; if (c_ovld !== 1'b1) begin fails++; $display("FAIL ng1_vld_a: got %0d expected 1", c_ovld); end
    tests++; if (c_rdy !== 1'b0) begin fails++; $display("FAIL ng1_rdy_a: got %0d expected 0", c_rdy); end
    tests++; if (c_cnt !== 1'd1) begin fails++; $display("FAIL ng1_cnt_a: got %0d expected 1", c_cnt); end
    tests++; if (c_dout[0] !== 12'd5) begin fails++; $display("FAIL ng1_ch0_a: got %0d expected 5", $signed(c_dout[0])); end
    tests++; if (c_dout[63] !== 12'd5) begin fails++; $display("FAIL ng1_ch63_a: got %0d expected 5", $signed(c_dout[63])); end
    for (int k = 0; k < CH; k++) c_din[k] = 8'hF9;
    tick();
    tests++; if (c_ovld !== 1'b0) begin fails++; $display("FAIL ng1_gap_vld: got %0d expected 0", c_ovld); end
    tests++; if (c_rdy !== 1'b1) begin fails++; $display("FAIL ng1_gap_rdy: got %0d expected 1", c_rdy); end
    tests++; if (c_dout[0] !== 12'd5) begin fails++; $display("FAIL ng1_gap_ch0: got %0d expected 5", $signed(c_dout[0])); end
    tick();
    c_vld = 1'b0;
    tests++; if (c_ovld !== 1'b1) begin fails++; $display("FAIL ng1_vld_b: got %0d expected 1", c_ovld); end
    tests++; if (c_rdy !== 1'b0) begin fails++; $display("FAIL ng1_rdy_b: got %0d expected 0", c_rdy); end
    tests++; if (c_dout[0] !== 12'hFF9) begin fails++; $display("FAIL ng1_ch0_b: got %0d expected -7", $signed(c_dout[0])); end
    tests++; if (c_dout[63] !== 12'hFF9) begin fails++; $display("FAIL ng1_ch63_b: got %0d expected -7", $signed(c_dout[63])); end
    tick();
    tests++; if (c_ovld !== 1'b0) begin fails++; $display("FAIL ng1_vld_end: got %0d expected 0", c_ovld); end
    tests++; if (c_cnt !== 1'd0) begin fails++; $display("FAIL ng1_cnt_end: got %0d expected 0", c_cnt); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_mixed();
    test_x_ignored();
    test_backpressure();
    test_reset_mid();
    test_saturation();
    test_num_groups_one();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/psum_accumulator.md
Name: psum_accumulator

Overview:
Consumer of the 64-channel signed 8-bit partial-sum stream (data_out_valid / data_out) produced by the layer's partial-sum stage. It accumulates NUM_GROUPS consecutive valid beats per channel into wider saturating accumulators. It then presents the completed 64-channel result with a valid/ready handshake to the downstream stage (BN/activation). While a result is pending it back-pressures its upstream via data_in_ready.

Parameters:
CH, 64, number of channels per beat
IN_W, 8, signed width of each input partial sum
ACC_W, 12, signed width of each accumulator/output element
NUM_GROUPS, 9, beats accumulated per result (>=1)

Ports:
clk  input  1  clock
rst  input  1  asynchronous, active-high reset
data_in_valid  input  1  input beat valid
data_in_ready  output  1  block can accept a beat this cycle
data_in  input  CH x IN_W signed  per-channel partial sums
data_out_valid  output  1  completed result held on data_out
data_out_ready  input  1  downstream accepts result
data_out  output  CH x ACC_W signed  accumulated per-channel sums
group_cnt  output  ceil(log2(NUM_GROUPS+1))  beats accumulated into current result

Behaviour:
- Reset (async, rst=1): state=ACCUM; group_cnt=0; all data_out/accumulators=0; data_out_valid=0; data_in_ready=1 from the first cycle after reset release.
- The input beat fires when data_in_valid & data_in_ready. The output beat fires when data_out_valid & data_out_ready.
- States:
  - ACCUM: data_in_ready=1, data_out_valid=0.
  - HOLD: data_in_ready=0, data_out_valid=1, data_out stable.
- ACCUM, input fire with group_cnt==0: acc[k] <= sign-extend(data_in[k]). This discards the previous result; no explicit clear is required.
- ACCUM, input fire with group_cnt>0: acc[k] <= sat(acc[k] + sext(data_in[k])).
- ACCUM, firing beat is the last (group_cnt==NUM_GROUPS-1): acc updated as above, group_cnt <= NUM_GROUPS, next state HOLD.
- ACCUM, other firing beats: group_cnt increments.
- ACCUM, no fire: everything holds.
- Latency: data_out_valid rises on the clock edge that captures the last beat, so the result is visible in the following cycle.
- HOLD, data_out_ready=1: data_out_valid <= 0, group_cnt <= 0, state <= ACCUM. data_out retains its value until overwritten by the next first beat.
- HOLD, data_out_ready=0: everything holds indefinitely. data_in_valid is ignored; upstream must hold its beat.
- NUM_GROUPS=1: every accepted beat goes straight to HOLD.
- Saturation: sum computed at ACC_W+1 bits.
  - Result > 2^(ACC_W-1)-1 clamps to 2^(ACC_W-1)-1 (2047 at default).
  - Result < -2^(ACC_W-1) clamps to -2^(ACC_W-1) (-2048).
  - Each channel saturates independently; a saturated value continues accumulating from the clamped value.
- No combinational path from data_in_valid or data_out_ready to any output. data_in_ready and data_out_valid are registered/state-decoded.
- Reset mid-accumulation or mid-HOLD aborts immediately. The partial result is lost and outputs return to reset values asynchronously.
- X on data_in while no input fire must not affect the accumulators.

Test Plan:
- Basic sum: 9 beats, all channels =+3, data_out_ready=1 -> data_out_valid high exactly 1 cycle after 9th beat; every data_out[k]=27; group_cnt 0..9; back to ACCUM next cycle.
- Mixed signs/channels: 9 beats with data_in[k]=k-32 each beat, one bubble (valid=0) inserted after beat 4 -> data_out[k]=9*(k-32) (e.g. ch0=-288, ch63=279); the bubble does not advance group_cnt.
- Back-pressure: result ready, hold data_out_ready=0 for 5 cycles while driving data_in_valid=1 -> data_in_ready=0, data_out stable, group_cnt=9; ready=1 -> valid drops next cycle, the next beat accepted becomes the first of the new group (data_out[k]=new value, not summed with the old).
- Saturation: NUM_GROUPS=32, all beats +127 on ch0 and -128 on ch1 -> ch0=2047, ch1=-2048; ch2 driven +1 -> 32.
- Reset mid-operation: assert rst after beat 5 (async, between edges) -> data_out_valid=0, data_in_ready=0 during reset, data_out=0, group_cnt=0 immediately; a fresh 9-beat group of +1 after release gives 9.
- NUM_GROUPS=1: consecutive beats 5, -7 with data_out_ready=1 -> results 5 then -7, each valid for 1 cycle, with data_in_ready low during each HOLD cycle.
